// File: rtl/add_pkg.sv
// ============================================================================
// add_pkg: shared flag indices, default requester count and FSM states. Rev 1.0
// ============================================================================
`default_nettype none

package add_pkg;

    // Bit positions inside the 5-bit flag vector produced by adder16bit
    localparam int SIGN   = 4;
    localparam int ZERO   = 3;
    localparam int CARRY  = 2;
    localparam int PARITY = 1;
    localparam int OVF    = 0;

    localparam int DEFAULT_NREQ = 4;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/add_rr_pick.sv
// ============================================================================
// add_rr_pick: first valid index at or after ptr, wrapping modulo NREQ. Rev 1.0
// ============================================================================
`default_nettype none

module add_rr_pick
    import add_pkg::*;
#(
    parameter int NREQ = DEFAULT_NREQ,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx
);

    logic           hit_hi;
    logic           hit_lo;
    logic [IDW-1:0] idx_hi;
    logic [IDW-1:0] idx_lo;

    // Two priority scans: the upper window [ptr, NREQ) wins, otherwise the
    // lowest valid index overall is the wrapped-around choice.
    always_comb begin
        hit_hi = 1'b0;
        hit_lo = 1'b0;
        idx_hi = '0;
        idx_lo = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!hit_hi && valid[i] && (i >= int'(ptr))) begin
                hit_hi = 1'b1;
                idx_hi = IDW'(i);
            end
            if (!hit_lo && valid[i]) begin
                hit_lo = 1'b1;
                idx_lo = IDW'(i);
            end
        end
    end

    assign idx = hit_hi ? idx_hi : idx_lo;

    always_comb begin
        grant = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant[i] = hit_lo && (idx == IDW'(i));
        end
    end

endmodule

`default_nettype wire

// File: rtl/adder16bit.sv
// ============================================================================
// adder16bit: 16-bit adder with {sign, zero, carry, parity, overflow}. Rev 1.0
// ============================================================================
`default_nettype none

module adder16bit (
    input  logic [15:0] x,
    input  logic [15:0] y,
    output logic [15:0] z,
    output logic [4:0]  flags
);

    logic [16:0] sum;
    logic        sign;
    logic        zero;
    logic        carry;
    logic        parity;
    logic        overflow;

    assign sum      = {1'b0, x} + {1'b0, y};
    assign z        = sum[15:0];
    assign sign     = sum[15];
    assign zero     = ~|sum[15:0];
    assign carry    = sum[16];
    // Parity is the XOR reduction: set when the sum has an odd number of ones
    assign parity   = ^sum[15:0];
    assign overflow = (x[15] == y[15]) && (sum[15] != x[15]);

    assign flags = {sign, zero, carry, parity, overflow};

endmodule

`default_nettype wire

// File: rtl/add_arbiter.sv
// ============================================================================
// add_arbiter: round-robin arbitration of NREQ requesters onto one adder. Rev 1.0
// ============================================================================
`default_nettype none

module add_arbiter
    import add_pkg::*;
#(
    parameter int NREQ = DEFAULT_NREQ,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [16*NREQ-1:0]   req_x,
    input  logic [16*NREQ-1:0]   req_y,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [15:0]          rsp_z,
    output logic [4:0]           rsp_flags
);

    state_t          state;
    state_t          state_nxt;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  ptr_nxt;
    logic            free;
    logic            accept;
    logic            drain;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic [15:0]     op_x;
    logic [15:0]     op_y;
    logic [15:0]     sum;
    logic [4:0]      flags;

    add_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .valid (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (grant_idx)
    );

    assign rsp_valid = (state == FULL);
    assign free      = !rsp_valid || rsp_ready;
    assign drain     = rsp_valid && rsp_ready;
    // rst_n gates the grant so req_ready drops the moment reset asserts
    assign req_ready = (rst_n && free) ? grant : '0;
    assign accept    = |req_ready;

    // One-hot AND-OR operand mux driven by the picker's grant
    always_comb begin
        op_x = '0;
        op_y = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                op_x = op_x | req_x[16*i +: 16];
                op_y = op_y | req_y[16*i +: 16];
            end
        end
    end

    adder16bit u_adder (
        .x     (op_x),
        .y     (op_y),
        .z     (sum),
        .flags (flags)
    );

    assign ptr_nxt = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);

    always_comb begin
        state_nxt = state;
        unique case (state)
            EMPTY: if (accept)           state_nxt = FULL;
            FULL:  if (drain && !accept) state_nxt = EMPTY;
            default:                     state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            ptr       <= '0;
            rsp_id    <= '0;
            rsp_z     <= '0;
            rsp_flags <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                ptr       <= ptr_nxt;
                rsp_id    <= grant_idx;
                rsp_z     <= sum;
                rsp_flags <= flags;
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/add_arbiter.md
ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the adder; the block SHALL support 2..8.
REQ-002 Parameter IDW, default 2, requester-id width; the block SHALL require IDW = clog2(NREQ).
REQ-003 Port clk, input, 1: the single clock; all state SHALL be on its rising edge.
REQ-004 Port rst_n, input, 1: asynchronous active-low reset.
REQ-005 Port req_valid, input, NREQ: per-requester operand valid.
REQ-006 Port req_ready, output, NREQ: per-requester accept (one-hot or zero).
REQ-007 Port req_x, input, 16*NREQ: packed operand x; requester i occupies bits [16i+15:16i].
REQ-008 Port req_y, input, 16*NREQ: packed operand y, same packing.
REQ-009 Port rsp_valid, output, 1: result register holds a valid result.
REQ-010 Port rsp_ready, input, 1: consumer accepts the result.
REQ-011 Port rsp_id, output, IDW: index of the requester that owns the result.
REQ-012 Port rsp_z, output, 16: sum.
REQ-013 Port rsp_flags, output, 5: {sign, zero, carry, parity, overflow} as produced by adder16bit.

Function
REQ-014 The block SHALL contain exactly one adder16bit instance, shared by all requesters.
REQ-015 Transfer rule: a request transfers when req_valid[i] & req_ready[i]; a response transfers when rsp_valid & rsp_ready.
REQ-016 free = !rsp_valid | rsp_ready; req_ready SHALL be all-zero when free = 0.
REQ-017 When free = 1, req_ready SHALL assert for exactly one valid requester: the first valid index at or after ptr, searching upward mod NREQ.
REQ-018 req_ready MAY depend combinationally on req_valid and rsp_ready; no other input-to-output combinational path is permitted.
REQ-019 The adder SHALL be fed the granted requester's x/y through a mux; on accept, z, flags and id SHALL load into the result register, with rsp_valid = 1 on the next cycle (latency 1).
REQ-020 Round-robin pointer: on accept from index g, ptr SHALL become (g+1) mod NREQ; with no accept, ptr SHALL hold.
REQ-021 State machine, two states: EMPTY (rsp_valid = 0) and FULL (rsp_valid = 1).
REQ-022 EMPTY->FULL on accept; FULL->EMPTY on drain with no accept; FULL->FULL on accept + drain in the same cycle, with no bubble.
REQ-023 While FULL and rsp_ready = 0, rsp_id/rsp_z/rsp_flags SHALL be held stable.
REQ-024 No requester may wait more than NREQ-1 accepts once its req_valid is held high.
REQ-025 No valid requests: no state change except a drain.

Reset
REQ-026 With rst_n low: rsp_valid = 0, rsp_id = 0, rsp_z = 0, rsp_flags = 0, ptr = 0, state EMPTY, req_ready = 0, all asynchronously.
REQ-027 Reset mid-operation SHALL discard any held result without emitting it.
REQ-028 After deassertion, the first accept SHALL follow the REQ-017 search from index 0.

Structure
REQ-029 Shared package add_pkg SHALL hold the flag bit-index constants (SIGN=4, ZERO=3, CARRY=2, PARITY=1, OVF=0), the default NREQ, and the state enumeration.
REQ-030 The round-robin search SHALL be a sub-module add_rr_pick (inputs: valid vector, ptr; outputs: one-hot grant, index); adder16bit SHALL be reused unmodified.

Verification
REQ-031 Single requester 0 with x=8fff, y=8000, rsp_ready=1 -> next cycle rsp_valid=1, id=0, z=0fff, sign=0, zero=0, carry=1, overflow=1.
REQ-032 Requester 2 with x=fffe, y=0002 -> z=0000, zero=1, carry=1, overflow=0, sign=0, id=2.
REQ-033 All four requesters valid with aaaa+5555 continuously, rsp_ready=1 -> ids 0,1,2,3,0 on consecutive cycles, each z=ffff, sign=1, carry=0, overflow=0, and no idle cycles.
REQ-034 rsp_ready=0 for 3 cycles while FULL -> req_ready=0 and outputs stable; rsp_ready=1 -> drain and next accept occur in the same cycle.
REQ-035 rst_n pulsed low while FULL -> rsp_valid=0 immediately, ptr=0; after release, with requesters 1 and 3 valid, requester 1 is granted first.
REQ-036 Parity flag checked against an independent reference model of adder16bit for random operands across all requesters.
